// File: rtl/pc_branch_unit.sv
// Program counter with conditional branch, call/return stack and sticky stack-error flag.
// PC updates one edge after the decision; EN=0 stalls everything and forces ESCR_PC low.
module pc_branch_unit #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int SD = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          EN,
  input  logic          S_FLAG,
  input  logic [DW-1:0] OPERANDO1,
  input  logic [2:0]    SEL_PC,
  input  logic [AW-1:0] TARGET,
  input  logic          CALL,
  input  logic          RET,
  output logic [AW-1:0] PC,
  output logic          ESCR_PC,
  output logic          STK_FULL,
  output logic          STK_EMPTY,
  output logic          STK_ERR
);

  localparam int PW = $clog2(SD + 1);
  localparam int IW = $clog2(SD);

  logic [AW-1:0] stk [SD];
  logic [PW-1:0] sp;
  logic [PW-1:0] sp_dec;
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] pc_nxt;
  logic          cond;
  logic          do_ret;
  logic          ret_err;
  logic          do_call;
  logic          call_err;
  logic          do_br;

  always_comb begin
    cond = 1'b0;
    case (SEL_PC)
      3'b000: cond = 1'b0;
      3'b001: cond = 1'b1;
      3'b010: cond = S_FLAG;
      3'b011: cond = ~S_FLAG;
      3'b100: cond = OPERANDO1[DW-1];
      3'b101: cond = ~OPERANDO1[DW-1];
      3'b110: cond = (OPERANDO1 == '0);
      3'b111: cond = (OPERANDO1 != '0);
      default: cond = 1'b0;
    endcase
  end

  assign pc_inc    = PC + {{(AW-1){1'b0}}, 1'b1};
  assign sp_dec    = sp - {{(PW-1){1'b0}}, 1'b1};
  assign STK_FULL  = (sp == PW'(SD));
  assign STK_EMPTY = (sp == '0);

  // RET outranks CALL; a CALL shadowed by RET is silently dropped.
  assign do_ret   = EN & RET & ~STK_EMPTY;
  assign ret_err  = EN & RET & STK_EMPTY;
  assign do_call  = EN & CALL & ~RET & ~STK_FULL;
  assign call_err = EN & CALL & ~RET & STK_FULL;
  assign do_br    = EN & cond & ~CALL & ~RET;

  assign ESCR_PC = do_ret | do_call | do_br;

  always_comb begin
    pc_nxt = pc_inc;
    if (do_ret) begin
      pc_nxt = stk[sp_dec[IW-1:0]];
    end else if (do_call || do_br) begin
      pc_nxt = TARGET;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      PC      <= RESET_PC;
      sp      <= '0;
      STK_ERR <= 1'b0;
      for (int i = 0; i < SD; i++) begin
        stk[i] <= '0;
      end
    end else if (EN) begin
      PC <= pc_nxt;
      if (do_call) begin
        stk[sp[IW-1:0]] <= pc_inc;
        sp              <= sp + {{(PW-1){1'b0}}, 1'b1};
      end else if (do_ret) begin
        sp <= sp_dec;
      end
      if (ret_err || call_err) begin
        STK_ERR <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Bench for pc_branch_unit: directed scenarios plus random traffic against a queue-based model.
module tb_pc_branch_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       s_flag;
  logic       call;
  logic       ret;
  logic [7:0] operando1;
  logic [7:0] target;
  logic [2:0] sel_pc;
  logic [7:0] pc;
  logic       escr_pc;
  logic       stk_full;
  logic       stk_empty;
  logic       stk_err;

  int checks   = 0;
  int failures = 0;

  logic [7:0] m_pc;
  logic [7:0] m_stk[$];
  logic       m_err;

  pc_branch_unit #(.AW(8), .DW(8), .SD(4), .RESET_PC(8'h00)) dut (
    .CLK(clk), .RST_N(rst_n), .EN(en), .S_FLAG(s_flag), .OPERANDO1(operando1),
    .SEL_PC(sel_pc), .TARGET(target), .CALL(call), .RET(ret), .PC(pc),
    .ESCR_PC(escr_pc), .STK_FULL(stk_full), .STK_EMPTY(stk_empty), .STK_ERR(stk_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 8'h00;
    m_stk.delete();
    m_err = 1'b0;
  endtask

  function automatic logic m_cond();
    case (sel_pc)
      3'd0: return 1'b0;
      3'd1: return 1'b1;
      3'd2: return s_flag;
      3'd3: return !s_flag;
      3'd4: return operando1 >= 8'h80;
      3'd5: return operando1 < 8'h80;
      3'd6: return operando1 == 8'h00;
      default: return operando1 != 8'h00;
    endcase
  endfunction

  // Checks ESCR_PC before the edge, then PC and stack flags after it.
  task automatic step();
    logic [7:0] nxt;
    logic       take;
    #1;
    take = 1'b0;
    nxt  = m_pc + 8'd1;
    if (!en) begin
      nxt = m_pc;
    end else if (ret) begin
      if (m_stk.size() > 0) begin
        take = 1'b1;
        nxt  = m_stk.pop_back();
      end else begin
        m_err = 1'b1;
      end
    end else if (call) begin
      if (m_stk.size() < 4) begin
        take = 1'b1;
        m_stk.push_back(m_pc + 8'd1);
        nxt = target;
      end else begin
        m_err = 1'b1;
      end
    end else if (m_cond()) begin
      take = 1'b1;
      nxt  = target;
    end
    check("escr_pc", escr_pc, take);
    @(posedge clk);
    #1;
    m_pc = nxt;
    check("pc", pc, m_pc);
    check("stk_full", stk_full, m_stk.size() == 4);
    check("stk_empty", stk_empty, m_stk.size() == 0);
    check("stk_err", stk_err, m_err);
  endtask

  task automatic drive(input logic e, input logic c, input logic r, input logic [2:0] sel,
                       input logic [7:0] tgt, input logic [7:0] op, input logic sf);
    en = e; call = c; ret = r; sel_pc = sel; target = tgt; operando1 = op; s_flag = sf;
    step();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_pc", pc, 8'h00);
    check("rst_empty", stk_empty, 1'b1);
    check("rst_full", stk_full, 1'b0);
    check("rst_err", stk_err, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_seq[5];
    rst_n = 1'b0; en = 1'b0; call = 1'b0; ret = 1'b0; sel_pc = 3'd0;
    target = 8'h00; operando1 = 8'h00; s_flag = 1'b0;
    model_reset();
    #2;
    check("reset_pc", pc, 8'h00);
    check("reset_empty", stk_empty, 1'b1);
    check("reset_full", stk_full, 1'b0);
    check("reset_err", stk_err, 1'b0);
    #6;
    rst_n = 1'b1;

    // Sequential advance
    for (int i = 1; i <= 3; i++) begin
      drive(1, 0, 0, 3'd0, 8'hAA, 8'h00, 0);
      check("seq_pc", pc, i);
    end

    // Sign branch taken and not taken from PC=0x05
    drive(1, 0, 0, 3'd1, 8'h05, 8'h00, 0);
    drive(1, 0, 0, 3'd4, 8'h40, 8'h80, 0);
    check("sign_taken", pc, 8'h40);
    drive(1, 0, 0, 3'd1, 8'h05, 8'h00, 0);
    drive(1, 0, 0, 3'd4, 8'h40, 8'h7F, 0);
    check("sign_not_taken", pc, 8'h06);

    // Wrap and stall
    drive(1, 0, 0, 3'd1, 8'hFF, 8'h00, 0);
    drive(1, 0, 0, 3'd0, 8'h33, 8'h00, 0);
    check("wrap", pc, 8'h00);
    drive(0, 0, 0, 3'd1, 8'h77, 8'h00, 0);
    check("stall_pc", pc, 8'h00);

    // Overflow: five CALLs
    exp_seq = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 0, 3'd0, 8'h10 + 8'(i), 8'h00, 0);
      check("call_pc", pc, exp_seq[i]);
      if (i == 3) check("full_after_4", stk_full, 1'b1);
    end
    check("ovf_err", stk_err, 1'b1);

    // Unwind and underflow: five RETs
    exp_seq = '{8'h13, 8'h12, 8'h11, 8'h01, 8'h02};
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 1, 3'd0, 8'h00, 8'h00, 0);
      check("ret_pc", pc, exp_seq[i]);
      if (i == 3) check("empty_after_4", stk_empty, 1'b1);
    end
    check("err_sticky", stk_err, 1'b1);

    // Simultaneous CALL+RET with one entry (0x22)
    pulse_reset();
    drive(1, 0, 0, 3'd1, 8'h21, 8'h00, 0);
    drive(1, 1, 0, 3'd0, 8'h50, 8'h00, 0);
    drive(1, 1, 1, 3'd1, 8'h99, 8'h00, 1);
    check("both_pc", pc, 8'h22);
    check("both_empty", stk_empty, 1'b1);
    check("both_err", stk_err, 1'b0);

    // Reset mid-operation with entries pending
    drive(1, 1, 0, 3'd0, 8'h60, 8'h00, 0);
    drive(1, 1, 0, 3'd0, 8'h70, 8'h00, 0);
    en = 1'b1; call = 1'b1; ret = 1'b0; target = 8'h80;
    pulse_reset();
    drive(1, 0, 0, 3'd0, 8'h00, 8'h00, 0);
    check("post_rst_pc", pc, 8'h01);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      logic [7:0] op;
      case ($urandom_range(3))
        0: op = 8'h00;
        1: op = 8'h80;
        default: op = 8'($urandom);
      endcase
      drive($urandom_range(9) != 0, $urandom_range(2) == 0, $urandom_range(3) == 0,
            3'($urandom_range(7)), 8'($urandom), op, 1'($urandom));
      if ($urandom_range(79) == 0) pulse_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_branch_unit.md
PC_BRANCH_UNIT -- requirements
Module: pc_branch_unit

Interface
REQ-001 The block SHALL have a single clock; reset SHALL be asynchronous and active-low.
REQ-002 Parameter AW, default 8, SHALL set the program-counter and target width in bits.
REQ-003 Parameter DW, default 8, SHALL set the operand width in bits.
REQ-004 Parameter SD, default 4, SHALL set the return-stack depth in entries (SD >= 2).
REQ-005 Parameter RESET_PC, default 0, SHALL set the PC value loaded on reset.
REQ-006 CLK  in  1  rising-edge clock.
REQ-007 RST_N  in  1  asynchronous active-low reset.
REQ-008 EN  in  1  advance enable; 0 = stall.
REQ-009 S_FLAG  in  1  status flag used as a branch condition.
REQ-010 OPERANDO1  in  DW  operand tested for sign and zero.
REQ-011 SEL_PC  in  3  branch-condition select.
REQ-012 TARGET  in  AW  branch or call target address.
REQ-013 CALL  in  1  call request: push return address, jump to TARGET.
REQ-014 RET  in  1  return request: pop return address.
REQ-015 PC  out  AW  registered program counter.
REQ-016 ESCR_PC  out  1  combinational flag; 1 = the next edge loads a non-sequential PC.
REQ-017 STK_FULL  out  1  return stack holds SD entries.
REQ-018 STK_EMPTY  out  1  return stack holds 0 entries.
REQ-019 STK_ERR  out  1  sticky overflow/underflow flag.

Function
REQ-020 The condition cond SHALL be decoded from SEL_PC as follows:
- 000 = 0
- 001 = 1
- 010 = S_FLAG
- 011 = !S_FLAG
- 100 = OPERANDO1[DW-1]
- 101 = !OPERANDO1[DW-1]
- 110 = (OPERANDO1 == 0)
- 111 = (OPERANDO1 != 0)
REQ-021 On a rising edge with EN=1, the PC update SHALL use priority RET > CALL > branch (cond=1) > increment.
REQ-022 On RET with the stack non-empty, PC SHALL load the top entry and the stack SHALL pop.
REQ-023 On RET with the stack empty, the block SHALL set STK_ERR, set PC <= PC+1, and leave the stack unchanged.
REQ-024 On CALL (RET=0) with the stack not full, the block SHALL push (PC+1) mod 2^AW and set PC <= TARGET.
REQ-025 On CALL (RET=0) with the stack full, the block SHALL set STK_ERR, suppress the push and jump, and set PC <= PC+1.
REQ-026 When CALL and RET are both 1, RET SHALL take effect and CALL SHALL be ignored without raising an error.
REQ-027 On a branch (CALL=RET=0, cond=1), PC SHALL load TARGET; otherwise PC <= (PC+1) mod 2^AW, wrapping from 2^AW-1 to 0.
REQ-028 When EN=0, PC, the stack, the stack pointer and STK_ERR SHALL hold their values; ESCR_PC SHALL be 0.
REQ-029 ESCR_PC SHALL equal EN & (successful RET | successful CALL | (cond & !CALL & !RET)), with no register stage.
REQ-030 A PC change SHALL take one cycle: a decision made in cycle n SHALL be visible on PC in cycle n+1.
REQ-031 STK_FULL and STK_EMPTY SHALL be derived from the registered stack pointer and SHALL update on the edge after a push or pop.
REQ-032 Once set, STK_ERR SHALL stay at 1 until reset.

Reset
REQ-033 While RST_N=0, and immediately without a clock edge, the block SHALL set PC=RESET_PC, stack pointer=0, all stack entries=0, STK_EMPTY=1, STK_FULL=0 and STK_ERR=0.
REQ-034 Reset asserted mid-operation SHALL abort any pending push or pop, with no partial update.
REQ-035 After RST_N rises, the first rising edge SHALL act on the inputs normally.

Verification (AW=8, DW=8, SD=4, RESET_PC=0)
REQ-036 Sequential: reset, then EN=1, SEL_PC=000 for 3 edges -> PC 0x00, 0x01, 0x02, 0x03 and ESCR_PC=0 throughout.
REQ-037 Sign branch, taken and not taken: PC=0x05, SEL_PC=100, TARGET=0x40.
- OPERANDO1=0x80 -> ESCR_PC=1, next PC=0x40.
- OPERANDO1=0x7F -> ESCR_PC=0, next PC=0x06.
REQ-038 Wrap and stall:
- PC=0xFF, SEL_PC=000 -> next PC=0x00.
- EN=0 with SEL_PC=001 -> PC held, ESCR_PC=0.
REQ-039 Overflow: from PC=0x00, issue CALLs to 0x10, 0x11, 0x12, 0x13, 0x14 on consecutive edges.
- PC sequence 0x10, 0x11, 0x12, 0x13, 0x14.
- STK_FULL=1 after the 4th CALL.
- The 5th CALL sets STK_ERR=1 with no push.
REQ-040 Unwind and underflow: following REQ-039, issue 5 RETs.
- PC sequence 0x13, 0x12, 0x11, 0x01, 0x02.
- STK_EMPTY=1 after the 4th RET.
- STK_ERR stays 1.
REQ-041 Simultaneous request and reset:
- With one entry (0x22) on the stack, CALL=RET=1 -> PC=0x22, STK_EMPTY=1, STK_ERR=0.
- RST_N pulsed low between edges -> PC=0x00 and flags reset before the next edge.
